// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - requester handshake and SRAM macro bus bundle for sram_port_arbiter
interface sram_port_arbiter_if #(
    parameter int ADDR_BITS = 14,
    parameter int DATA_BITS = 32,
    parameter int STRB_BITS = 4,
    parameter int LEN_BITS  = 4
);
    logic                 req_valid_0, req_valid_1;
    logic                 req_ready_0, req_ready_1;
    logic                 req_write_0, req_write_1;
    logic [ADDR_BITS-1:0] req_addr_0, req_addr_1;
    logic [LEN_BITS-1:0]  req_len_0, req_len_1;
    logic [DATA_BITS-1:0] wdata_0, wdata_1;
    logic [STRB_BITS-1:0] wstrb_0, wstrb_1;
    logic                 rvalid_0, rvalid_1;
    logic [DATA_BITS-1:0] rdata;
    logic                 CEB;
    logic                 WEB;
    logic [DATA_BITS-1:0] BWEB;
    logic [ADDR_BITS-1:0] A;
    logic [DATA_BITS-1:0] D;
    logic [DATA_BITS-1:0] Q;

    modport slave (
        input  req_valid_0, req_valid_1, req_write_0, req_write_1,
        input  req_addr_0, req_addr_1, req_len_0, req_len_1,
        input  wdata_0, wdata_1, wstrb_0, wstrb_1, Q,
        output req_ready_0, req_ready_1, rvalid_0, rvalid_1, rdata,
        output CEB, WEB, BWEB, A, D
    );

    modport master (
        output req_valid_0, req_valid_1, req_write_0, req_write_1,
        output req_addr_0, req_addr_1, req_len_0, req_len_1,
        output wdata_0, wdata_1, wstrb_0, wstrb_1, Q,
        input  req_ready_0, req_ready_1, rvalid_0, rvalid_1, rdata,
        input  CEB, WEB, BWEB, A, D
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-requester round-robin arbiter with burst locking for a single-port SRAM macro
module sram_port_arbiter #(
    parameter int ADDR_BITS = 14,
    parameter int DATA_BITS = 32,
    parameter int STRB_BITS = 4,
    parameter int LEN_BITS  = 4
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    sram_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t               state;
    logic                 last_grant;
    logic [LEN_BITS-1:0]  beat_cnt;
    logic [ADDR_BITS-1:0] burst_addr;
    logic                 burst_write;
    logic                 rvalid_0_q, rvalid_1_q;

    logic                 sel;
    logic                 sel_valid;
    logic                 owner_ready;
    logic                 accept;
    logic                 cur_write;
    logic [ADDR_BITS-1:0] cur_addr;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [LEN_BITS-1:0]  sel_len;
    logic                 sel_write;
    logic [STRB_BITS-1:0] sel_strb;
    logic [DATA_BITS-1:0] bweb;

    always_comb begin
        sel = 1'b0;
        case (state)
            // Ties go to the requester that did not win last time.
            IDLE:    sel = (bus.req_valid_0 && bus.req_valid_1) ? ~last_grant : bus.req_valid_1;
            LOCK0:   sel = 1'b0;
            LOCK1:   sel = 1'b1;
            default: sel = 1'b0;
        endcase

        sel_valid   = sel ? bus.req_valid_1 : bus.req_valid_0;
        sel_addr    = sel ? bus.req_addr_1  : bus.req_addr_0;
        sel_len     = sel ? bus.req_len_1   : bus.req_len_0;
        sel_write   = sel ? bus.req_write_1 : bus.req_write_0;
        sel_strb    = sel ? bus.wstrb_1     : bus.wstrb_0;
        owner_ready = (state == IDLE) ? sel_valid : 1'b1;
        accept      = owner_ready && sel_valid;
        cur_write   = (state == IDLE) ? sel_write : burst_write;
        cur_addr    = (state == IDLE) ? sel_addr  : burst_addr;

        bweb = '1;
        for (int k = 0; k < STRB_BITS; k++) begin
            if (accept && cur_write && sel_strb[k])
                bweb[k*8 +: 8] = 8'h00;
        end
    end

    assign bus.req_ready_0 = owner_ready && !sel;
    assign bus.req_ready_1 = owner_ready && sel;
    assign bus.CEB         = !accept;
    assign bus.WEB         = !(accept && cur_write);
    assign bus.BWEB        = bweb;
    assign bus.A           = (state == IDLE && !accept) ? '0 : cur_addr;
    assign bus.D           = sel ? bus.wdata_1 : bus.wdata_0;
    assign bus.rdata       = bus.Q;
    assign bus.rvalid_0    = rvalid_0_q;
    assign bus.rvalid_1    = rvalid_1_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            beat_cnt    <= '0;
            burst_addr  <= '0;
            burst_write <= 1'b0;
            rvalid_0_q  <= 1'b0;
            rvalid_1_q  <= 1'b0;
        end else begin
            rvalid_0_q <= accept && !cur_write && !sel;
            rvalid_1_q <= accept && !cur_write && sel;
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= sel;
                        if (sel_len != '0) begin
                            state       <= sel ? LOCK1 : LOCK0;
                            beat_cnt    <= sel_len;
                            burst_addr  <= sel_addr + ADDR_BITS'(1);
                            burst_write <= sel_write;
                        end
                    end
                end
                default: begin
                    // beat_cnt counts beats still owed after the first one.
                    if (accept) begin
                        burst_addr <= burst_addr + ADDR_BITS'(1);
                        beat_cnt   <= beat_cnt - LEN_BITS'(1);
                        if (beat_cnt == LEN_BITS'(1))
                            state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;
    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    int   passed = 0;
    int   total = 0;

    logic        bd_we = 1'b0;
    logic [13:0] bd_addr = '0;
    logic [31:0] bd_data = '0;
    logic [31:0] mem [0:16383];
    logic [31:0] wd [0:3];

    sram_port_arbiter_if #(.ADDR_BITS(14), .DATA_BITS(32), .STRB_BITS(4), .LEN_BITS(4)) bus ();

    sram_port_arbiter #(.ADDR_BITS(14), .DATA_BITS(32), .STRB_BITS(4), .LEN_BITS(4)) dut (
        .ACLK(ACLK),
        .ARESETn(ARESETn),
        .bus(bus)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        if (bd_we)
            mem[bd_addr] <= bd_data;
        else if (!bus.CEB) begin
            if (!bus.WEB)
                mem[bus.A] <= (mem[bus.A] & bus.BWEB) | (bus.D & ~bus.BWEB);
            else
                bus.Q <= mem[bus.A];
        end
    end

    task automatic step;
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_inputs;
        bus.req_valid_0 = 0; bus.req_valid_1 = 0;
        bus.req_write_0 = 0; bus.req_write_1 = 0;
        bus.req_addr_0 = '0; bus.req_addr_1 = '0;
        bus.req_len_0 = '0;  bus.req_len_1 = '0;
        bus.wdata_0 = '0;    bus.wdata_1 = '0;
        bus.wstrb_0 = '0;    bus.wstrb_1 = '0;
    endtask

    task automatic preload(input logic [13:0] a, input logic [31:0] d);
        bd_we = 1; bd_addr = a; bd_data = d;
        step();
        bd_we = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        ARESETn = 0;
        step(); step();
        #2;
        total++; if (bus.CEB !== 1'b1) $display("FAIL reset_ceb: got %b want 1", bus.CEB); else passed++;
        total++; if (bus.WEB !== 1'b1) $display("FAIL reset_web: got %b want 1", bus.WEB); else passed++;
        total++; if (bus.BWEB !== 32'hFFFF_FFFF) $display("FAIL reset_bweb: got %h want ffffffff", bus.BWEB); else passed++;
        total++; if (bus.A !== 14'h0) $display("FAIL reset_a: got %h want 0", bus.A); else passed++;
        total++; if ({bus.rvalid_0, bus.rvalid_1} !== 2'b00) $display("FAIL reset_rvalid: got %b want 00", {bus.rvalid_0, bus.rvalid_1}); else passed++;
        total++; if ({bus.req_ready_0, bus.req_ready_1} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {bus.req_ready_0, bus.req_ready_1}); else passed++;
        step();
        ARESETn = 1;
        step();
    endtask

    task automatic test_single_read;
        bus.req_valid_0 = 1; bus.req_write_0 = 0; bus.req_addr_0 = 14'h0010; bus.req_len_0 = 0;
        #2;
        total++; if ({bus.req_ready_0, bus.req_ready_1} !== 2'b10) $display("FAIL single_ready: got %b want 10", {bus.req_ready_0, bus.req_ready_1}); else passed++;
        total++; if ({bus.CEB, bus.WEB} !== 2'b01) $display("FAIL single_ceb_web: got %b want 01", {bus.CEB, bus.WEB}); else passed++;
        total++; if (bus.A !== 14'h0010) $display("FAIL single_a: got %h want 0010", bus.A); else passed++;
        step();
        bus.req_valid_0 = 0;
        total++; if ({bus.rvalid_0, bus.rvalid_1} !== 2'b10) $display("FAIL single_rvalid: got %b want 10", {bus.rvalid_0, bus.rvalid_1}); else passed++;
        total++; if (bus.rdata !== 32'hCAFE_0010) $display("FAIL single_rdata: got %h want cafe0010", bus.rdata); else passed++;
        #2;
        total++; if (bus.CEB !== 1'b1) $display("FAIL single_idle_ceb: got %b want 1", bus.CEB); else passed++;
        step();
        total++; if (bus.rvalid_0 !== 1'b0) $display("FAIL single_rvalid_drop: got %b want 0", bus.rvalid_0); else passed++;
    endtask

    task automatic test_write_burst;
        for (int i = 0; i < 4; i++) begin
            bus.req_valid_1 = 1; bus.req_write_1 = 1; bus.req_addr_1 = 14'h0100; bus.req_len_1 = 3;
            bus.wstrb_1 = 4'hF; bus.wdata_1 = wd[i];
            #2;
            total++; if (bus.req_ready_1 !== 1'b1) $display("FAIL wburst_ready beat %0d: got %b want 1", i, bus.req_ready_1); else passed++;
            total++; if ({bus.CEB, bus.WEB} !== 2'b00) $display("FAIL wburst_ceb_web beat %0d: got %b want 00", i, {bus.CEB, bus.WEB}); else passed++;
            total++; if (bus.A !== 14'h0100 + 14'(i)) $display("FAIL wburst_a beat %0d: got %h want %h", i, bus.A, 14'h0100 + 14'(i)); else passed++;
            total++; if (bus.BWEB !== 32'h0) $display("FAIL wburst_bweb beat %0d: got %h want 0", i, bus.BWEB); else passed++;
            total++; if (bus.D !== wd[i]) $display("FAIL wburst_d beat %0d: got %h want %h", i, bus.D, wd[i]); else passed++;
            step();
        end
        idle_inputs();
        #2;
        total++; if (bus.CEB !== 1'b1) $display("FAIL wburst_end_ceb: got %b want 1", bus.CEB); else passed++;
        step();
        for (int i = 0; i < 4; i++) begin
            bus.req_valid_1 = 1; bus.req_write_1 = 0; bus.req_addr_1 = 14'h0100; bus.req_len_1 = 3;
            #2;
            total++; if ({bus.CEB, bus.WEB, bus.A} !== {2'b01, 14'h0100 + 14'(i)}) $display("FAIL rburst_issue beat %0d: got %b/%h want 01/%h", i, {bus.CEB, bus.WEB}, bus.A, 14'h0100 + 14'(i)); else passed++;
            step();
            total++; if ({bus.rvalid_0, bus.rvalid_1} !== 2'b01) $display("FAIL rburst_rvalid beat %0d: got %b want 01", i, {bus.rvalid_0, bus.rvalid_1}); else passed++;
            total++; if (bus.rdata !== wd[i]) $display("FAIL rburst_rdata beat %0d: got %h want %h", i, bus.rdata, wd[i]); else passed++;
        end
        idle_inputs();
        step();
        total++; if (bus.rvalid_1 !== 1'b0) $display("FAIL rburst_rvalid_end: got %b want 0", bus.rvalid_1); else passed++;
    endtask

    task automatic test_contention;
        logic e0;
        idle_inputs();
        ARESETn = 0;
        step();
        ARESETn = 1;
        for (int i = 0; i < 4; i++) begin
            e0 = (i % 2 == 0);
            bus.req_valid_0 = 1; bus.req_addr_0 = 14'h0010; bus.req_len_0 = 0;
            bus.req_valid_1 = 1; bus.req_addr_1 = 14'h0100; bus.req_len_1 = 0;
            #2;
            total++; if ({bus.req_ready_0, bus.req_ready_1} !== {e0, !e0}) $display("FAIL rr_ready round %0d: got %b want %b", i, {bus.req_ready_0, bus.req_ready_1}, {e0, !e0}); else passed++;
            total++; if (bus.A !== (e0 ? 14'h0010 : 14'h0100)) $display("FAIL rr_a round %0d: got %h want %h", i, bus.A, e0 ? 14'h0010 : 14'h0100); else passed++;
            step();
            total++; if ({bus.rvalid_0, bus.rvalid_1} !== {e0, !e0}) $display("FAIL rr_rvalid round %0d: got %b want %b", i, {bus.rvalid_0, bus.rvalid_1}, {e0, !e0}); else passed++;
            total++; if (bus.rdata !== (e0 ? 32'hCAFE_0010 : wd[0])) $display("FAIL rr_rdata round %0d: got %h want %h", i, bus.rdata, e0 ? 32'hCAFE_0010 : wd[0]); else passed++;
        end
        bus.req_valid_1 = 0;
        step();
        // Requester 0 won last, so requester 1 takes the tie and locks for 3 beats.
        for (int j = 0; j < 3; j++) begin
            bus.req_valid_0 = 1; bus.req_len_0 = 0;
            bus.req_valid_1 = 1; bus.req_write_1 = 0; bus.req_addr_1 = 14'h0100; bus.req_len_1 = 2;
            #2;
            total++; if ({bus.req_ready_0, bus.req_ready_1} !== 2'b01) $display("FAIL lock1_ready beat %0d: got %b want 01", j, {bus.req_ready_0, bus.req_ready_1}); else passed++;
            total++; if (bus.A !== 14'h0100 + 14'(j)) $display("FAIL lock1_a beat %0d: got %h want %h", j, bus.A, 14'h0100 + 14'(j)); else passed++;
            step();
            total++; if (bus.rdata !== wd[j] || bus.rvalid_1 !== 1'b1) $display("FAIL lock1_rdata beat %0d: got %h/%b want %h/1", j, bus.rdata, bus.rvalid_1, wd[j]); else passed++;
        end
        #2;
        total++; if ({bus.req_ready_0, bus.req_ready_1} !== 2'b10) $display("FAIL lock1_then_grant0: got %b want 10", {bus.req_ready_0, bus.req_ready_1}); else passed++;
        idle_inputs();
        step();
    endtask

    task automatic test_strobes;
        preload(14'h0200, 32'h1122_3344);
        bus.req_valid_0 = 1; bus.req_write_0 = 1; bus.req_addr_0 = 14'h0200; bus.req_len_0 = 0;
        bus.wstrb_0 = 4'b0101; bus.wdata_0 = 32'hAABB_CCDD;
        #2;
        total++; if (bus.BWEB !== 32'hFF00_FF00) $display("FAIL strb_bweb: got %h want ff00ff00", bus.BWEB); else passed++;
        step();
        bus.wstrb_0 = 4'b0000; bus.wdata_0 = 32'h0;
        #2;
        total++; if ({bus.CEB, bus.WEB, bus.BWEB} !== {2'b00, 32'hFFFF_FFFF}) $display("FAIL strb_zero: got %b/%h want 00/ffffffff", {bus.CEB, bus.WEB}, bus.BWEB); else passed++;
        step();
        bus.req_write_0 = 0;
        #2;
        total++; if (bus.BWEB !== 32'hFFFF_FFFF) $display("FAIL strb_read_bweb: got %h want ffffffff", bus.BWEB); else passed++;
        step();
        idle_inputs();
        total++; if (bus.rdata !== 32'h11BB_33DD || bus.rvalid_0 !== 1'b1) $display("FAIL strb_readback: got %h/%b want 11bb33dd/1", bus.rdata, bus.rvalid_0); else passed++;
        step();
    endtask

    task automatic test_bubble_wrap;
        logic        pat [0:7];
        logic [13:0] exp_a [0:3];
        logic [31:0] exp_d [0:3];
        int          k, r, pulses;
        pat = '{1, 1, 0, 0, 1, 1, 0, 0};
        exp_a = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
        exp_d = '{32'hB0B0_3FFE, 32'hB0B0_3FFF, 32'hB0B0_0000, 32'hB0B0_0001};
        for (int i = 0; i < 4; i++) preload(exp_a[i], exp_d[i]);
        k = 0; r = 0; pulses = 0;
        for (int c = 0; c < 8; c++) begin
            bus.req_valid_0 = pat[c]; bus.req_write_0 = 0; bus.req_addr_0 = 14'h3FFE; bus.req_len_0 = 3;
            #2;
            if (pat[c]) begin
                total++; if ({bus.CEB, bus.A} !== {1'b0, exp_a[k]}) $display("FAIL wrap_issue beat %0d: got %b/%h want 0/%h", k, bus.CEB, bus.A, exp_a[k]); else passed++;
                k++;
            end else begin
                total++; if (bus.CEB !== 1'b1) $display("FAIL bubble_ceb cycle %0d: got %b want 1", c, bus.CEB); else passed++;
            end
            step();
            if (bus.rvalid_0 === 1'b1) begin
                pulses++;
                if (r < 4) begin
                    total++; if (bus.rdata !== exp_d[r]) $display("FAIL wrap_rdata beat %0d: got %h want %h", r, bus.rdata, exp_d[r]); else passed++;
                end
                r++;
            end
        end
        total++; if (pulses !== 4) $display("FAIL wrap_pulses: got %0d want 4", pulses); else passed++;
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst;
        bus.req_valid_0 = 1; bus.req_write_0 = 0; bus.req_addr_0 = 14'h0100; bus.req_len_0 = 7;
        step(); step();
        ARESETn = 0;
        step();
        total++; if ({bus.rvalid_0, bus.rvalid_1} !== 2'b00) $display("FAIL midrst_rvalid: got %b want 00", {bus.rvalid_0, bus.rvalid_1}); else passed++;
        bus.req_valid_0 = 0;
        #2;
        total++; if ({bus.CEB, bus.req_ready_0} !== 2'b10) $display("FAIL midrst_idle: got ceb/ready0 %b want 10", {bus.CEB, bus.req_ready_0}); else passed++;
        bus.req_valid_1 = 1;
        #1;
        total++; if (bus.req_ready_1 !== 1'b1) $display("FAIL midrst_unlocked: got %b want 1", bus.req_ready_1); else passed++;
        bus.req_valid_1 = 0;
        ARESETn = 1;
        step();
        bus.req_valid_0 = 1; bus.req_valid_1 = 1;
        #2;
        total++; if ({bus.req_ready_0, bus.req_ready_1} !== 2'b10) $display("FAIL midrst_first_grant: got %b want 10", {bus.req_ready_0, bus.req_ready_1}); else passed++;
        step();
        idle_inputs();
        step();
    endtask

    initial begin
        wd[0] = 32'h0123_4567; wd[1] = 32'h89AB_CDEF; wd[2] = 32'hDEAD_BEEF; wd[3] = 32'hFEED_F00D;
        idle_inputs();
        preload(14'h0010, 32'hCAFE_0010);
        test_reset();
        test_single_read();
        test_write_burst();
        test_contention();
        test_strobes();
        test_bubble_wrap();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
